// File: rtl/encoder_top.sv
// Serial unary/remainder codeword encoder with an NW-word readout buffer.
// Optional macro CW_BITCNT_EN adds a saturating count of accepted message bits.
module encoder_top #(
    parameter int CW_W = 18,
    parameter int NW   = 9,
    parameter int U    = 4,
    parameter int QMAX = 15
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            start,
    input  logic            bin_msg,
    input  logic            bit_vld,
    output logic            bit_rdy,
    input  logic            rd_en,
    output logic [CW_W-1:0] cw_byte,
    output logic            cw_rdy,
    output logic            cw_done
`ifdef CW_BITCNT_EN
    ,
    output logic [15:0]     bit_cnt
`endif
);

    localparam int QW = (QMAX > 1) ? $clog2(QMAX + 1) : 1;
    localparam int AW = (NW > 1) ? $clog2(NW) : 1;
    localparam int PW = $clog2(NW + 1);
    localparam int RW = $clog2(U + 1);

    typedef enum logic [2:0] {IDLE, UNARY, REM, STORE, DONE} state_t;

    state_t          state;
    logic [QW-1:0]   q;
    logic [U-1:0]    r;
    logic [RW-1:0]   rem_cnt;
    logic [AW-1:0]   wr_idx;
    logic [PW-1:0]   rd_ptr;
    logic [CW_W-1:0] word_buf [NW];

    // NOTE: all state uses non-blocking assignments so every register sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        cw_rdy <= 1'b0;
        if (rst_b) begin
            state   <= IDLE;
            q       <= '0;
            r       <= '0;
            rem_cnt <= '0;
            wr_idx  <= '0;
            rd_ptr  <= '0;
            bit_rdy <= 1'b0;
            cw_done <= 1'b0;
            cw_byte <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        q       <= '0;
                        r       <= '0;
                        rem_cnt <= '0;
                        wr_idx  <= '0;
                        rd_ptr  <= '0;
                        state   <= UNARY;
                        bit_rdy <= 1'b1;
                    end
                end
                UNARY: begin
                    if (bit_vld) begin
                        if (!bin_msg) begin
                            state <= REM;
                        end else begin
                            q <= q + QW'(1);
                            // A saturated quotient has no terminating zero.
                            if (q == QW'(QMAX - 1)) state <= REM;
                        end
                    end
                end
                REM: begin
                    if (bit_vld) begin
                        r <= U'({r, bin_msg});
                        if (rem_cnt == RW'(U - 1)) begin
                            rem_cnt <= '0;
                            state   <= STORE;
                            bit_rdy <= 1'b0;
                        end else begin
                            rem_cnt <= rem_cnt + RW'(1);
                        end
                    end
                end
                STORE: begin
                    q      <= '0;
                    r      <= '0;
                    wr_idx <= wr_idx + AW'(1);
                    if (wr_idx == AW'(NW - 1)) begin
                        state   <= DONE;
                        cw_done <= 1'b1;
                    end else begin
                        state   <= UNARY;
                        bit_rdy <= 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        q       <= '0;
                        r       <= '0;
                        rem_cnt <= '0;
                        wr_idx  <= '0;
                        rd_ptr  <= '0;
                        state   <= UNARY;
                        bit_rdy <= 1'b1;
                        cw_done <= 1'b0;
                    end else if (rd_en && (rd_ptr < PW'(NW))) begin
                        cw_byte <= word_buf[rd_ptr[AW-1:0]];
                        cw_rdy  <= 1'b1;
                        rd_ptr  <= rd_ptr + PW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    bit_rdy <= 1'b0;
                    cw_done <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the word buffer has no reset; every word is rewritten before it
    // can be read, so clearing it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (!rst_b && state == STORE) word_buf[wr_idx] <= CW_W'({q, r});
    end

`ifdef CW_BITCNT_EN
    always_ff @(posedge clk) begin
        if (rst_b) begin
            bit_cnt <= '0;
        end else if (start && (state == IDLE || state == DONE)) begin
            bit_cnt <= '0;
        end else if (bit_vld && bit_rdy && bit_cnt != 16'hFFFF) begin
            bit_cnt <= bit_cnt + 16'd1;
        end
    end
`endif

endmodule
